// File: rtl/rvfi_bus_arbiter_pkg.sv
// Shared FSM state type and byte-mask helper for rvfi_bus_arbiter.
package rvfi_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int MAX_BYTES = 32;

  // Expands a byte-enable mask into a bit mask; callers truncate to their bus width.
  function automatic logic [8*MAX_BYTES-1:0] expand_bytes(input logic [MAX_BYTES-1:0] mask);
    logic [8*MAX_BYTES-1:0] bits;
    bits = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      bits[8*i +: 8] = mask[i] ? 8'hFF : 8'h00;
    end
    return bits;
  endfunction

endpackage

// File: rtl/rvfi_bus_rr_pick.sv
// Round-robin picker: first valid requester at or after ptr, wrapping modulo NREQ.
module rvfi_bus_rr_pick
  import rvfi_bus_arbiter_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic            gnt_any,
  output logic [IW-1:0]   gnt_idx
);

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    logic [IW:0] idx;
    idx     = '0;
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = {1'b0, ptr} + (IW+1)'(i);
      if (idx >= (IW+1)'(NREQ)) begin
        idx = idx - (IW+1)'(NREQ);
      end else begin
        idx = idx;
      end
      if (valid[idx[IW-1:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = idx[IW-1:0];
      end else begin
        gnt_any = gnt_any;
      end
    end
  end

endmodule

// File: rtl/rvfi_bus_arbiter.sv
// Round-robin arbiter of NREQ requesters onto one memory port with an RVFI bus trace.
// Trace outputs are live only when RISCV_FORMAL_BUS_TRACE_EN is defined.
module rvfi_bus_arbiter
  import rvfi_bus_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int XLEN   = 32,
  parameter int BUSLEN = 32
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*XLEN-1:0]     req_addr,
  input  logic [NREQ*BUSLEN/8-1:0] req_rmask,
  input  logic [NREQ*BUSLEN/8-1:0] req_wmask,
  input  logic [NREQ*BUSLEN-1:0]   req_wdata,
  input  logic [NREQ-1:0]          req_data,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [BUSLEN-1:0]        rsp_rdata,
  output logic                     mem_valid,
  output logic [XLEN-1:0]          mem_addr,
  output logic [BUSLEN/8-1:0]      mem_wstrb,
  output logic [BUSLEN-1:0]        mem_wdata,
  input  logic                     mem_ready,
  input  logic [BUSLEN-1:0]        mem_rdata,
  output logic                     rvfi_bus_valid,
  output logic                     rvfi_bus_data,
  output logic [XLEN-1:0]          rvfi_bus_addr,
  output logic [BUSLEN/8-1:0]      rvfi_bus_rmask,
  output logic [BUSLEN/8-1:0]      rvfi_bus_wmask,
  output logic [BUSLEN-1:0]        rvfi_bus_rdata,
  output logic [BUSLEN-1:0]        rvfi_bus_wdata
);

  localparam int NB = BUSLEN / 8;
  localparam int IW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, gidx_q, gidx_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [NB-1:0]     rmask_q, rmask_d, wmask_q, wmask_d;
  logic [BUSLEN-1:0] wdata_q, wdata_d, rdata_q, rdata_d;

  logic              gnt_any_s, grant_s;
  logic [IW-1:0]     gnt_idx_s;
  logic [XLEN-1:0]   sel_addr_s;
  logic [NB-1:0]     sel_rmask_s, sel_wmask_s;
  logic [BUSLEN-1:0] sel_wdata_s;

  rvfi_bus_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .valid   (req_valid),
    .ptr     (ptr_q),
    .gnt_any (gnt_any_s),
    .gnt_idx (gnt_idx_s)
  );

  assign grant_s     = resetn && (state_q == ST_IDLE) && gnt_any_s;
  assign req_ready   = grant_s ? (NREQ'(1'b1) << gnt_idx_s) : '0;
  assign sel_addr_s  = req_addr[gnt_idx_s*XLEN +: XLEN];
  assign sel_rmask_s = req_rmask[gnt_idx_s*NB +: NB];
  assign sel_wmask_s = req_wmask[gnt_idx_s*NB +: NB];
  assign sel_wdata_s = req_wdata[gnt_idx_s*BUSLEN +: BUSLEN];

  // Read data is masked when captured, so rdata_q already holds only requested bytes.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    addr_d  = addr_q;
    rmask_d = rmask_q;
    wmask_d = wmask_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          gidx_d  = gnt_idx_s;
          addr_d  = sel_addr_s;
          rmask_d = sel_rmask_s;
          wmask_d = sel_wmask_s;
          wdata_d = sel_wdata_s;
          rdata_d = '0;
          state_d = ((sel_rmask_s | sel_wmask_s) == '0) ? ST_RESP : ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          rdata_d = mem_rdata & BUSLEN'(expand_bytes(MAX_BYTES'(rmask_q)));
          state_d = ST_RESP;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        ptr_d   = (gidx_q == IW'(NREQ - 1)) ? '0 : gidx_q + IW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      addr_q  <= '0;
      rmask_q <= '0;
      wmask_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      addr_q  <= addr_d;
      rmask_q <= rmask_d;
      wmask_q <= wmask_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_valid = (state_q == ST_BUSY);
  assign mem_addr  = mem_valid ? addr_q  : '0;
  assign mem_wstrb = mem_valid ? wmask_q : '0;
  assign mem_wdata = mem_valid ? wdata_q : '0;
  assign rsp_valid = (state_q == ST_RESP) ? (NREQ'(1'b1) << gidx_q) : '0;
  assign rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;

`ifdef RISCV_FORMAL_BUS_TRACE_EN
  logic              data_q, data_d;
  logic              trc_valid_q, trc_valid_d, trc_data_q, trc_data_d;
  logic [XLEN-1:0]   trc_addr_q, trc_addr_d;
  logic [NB-1:0]     trc_rmask_q, trc_rmask_d, trc_wmask_q, trc_wmask_d;
  logic [BUSLEN-1:0] trc_rdata_q, trc_rdata_d, trc_wdata_q, trc_wdata_d;

  // Trace record is loaded on the edge entering RESP and cleared on every other edge.
  always_comb begin
    data_d = grant_s ? req_data[gnt_idx_s] : data_q;
    if (state_d == ST_RESP) begin
      trc_valid_d = 1'b1;
      trc_data_d  = data_d;
      trc_addr_d  = addr_d;
      trc_rmask_d = rmask_d;
      trc_wmask_d = wmask_d;
      trc_rdata_d = rdata_d;
      trc_wdata_d = wdata_d;
    end else begin
      trc_valid_d = 1'b0;
      trc_data_d  = 1'b0;
      trc_addr_d  = '0;
      trc_rmask_d = '0;
      trc_wmask_d = '0;
      trc_rdata_d = '0;
      trc_wdata_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      data_q      <= 1'b0;
      trc_valid_q <= 1'b0;
      trc_data_q  <= 1'b0;
      trc_addr_q  <= '0;
      trc_rmask_q <= '0;
      trc_wmask_q <= '0;
      trc_rdata_q <= '0;
      trc_wdata_q <= '0;
    end else begin
      data_q      <= data_d;
      trc_valid_q <= trc_valid_d;
      trc_data_q  <= trc_data_d;
      trc_addr_q  <= trc_addr_d;
      trc_rmask_q <= trc_rmask_d;
      trc_wmask_q <= trc_wmask_d;
      trc_rdata_q <= trc_rdata_d;
      trc_wdata_q <= trc_wdata_d;
    end
  end

  assign rvfi_bus_valid = trc_valid_q;
  assign rvfi_bus_data  = trc_data_q;
  assign rvfi_bus_addr  = trc_addr_q;
  assign rvfi_bus_rmask = trc_rmask_q;
  assign rvfi_bus_wmask = trc_wmask_q;
  assign rvfi_bus_rdata = trc_rdata_q;
  assign rvfi_bus_wdata = trc_wdata_q;
`else
  logic unused_s;
  assign unused_s       = ^req_data;
  assign rvfi_bus_valid = 1'b0;
  assign rvfi_bus_data  = 1'b0;
  assign rvfi_bus_addr  = '0;
  assign rvfi_bus_rmask = '0;
  assign rvfi_bus_wmask = '0;
  assign rvfi_bus_rdata = '0;
  assign rvfi_bus_wdata = '0;
`endif

endmodule

// File: tb/tb_rvfi_bus_arbiter.sv
// Self-checking bench for rvfi_bus_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_rvfi_bus_arbiter;

  localparam int NREQ = 2;
  localparam int XLEN = 32;
  localparam int BUSLEN = 32;
  localparam int NB = 4;
`ifdef RISCV_FORMAL_BUS_TRACE_EN
  localparam bit TRACE = 1'b1;
`else
  localparam bit TRACE = 1'b0;
`endif

  logic clock = 1'b0;
  logic resetn;
  logic [NREQ-1:0] req_valid, req_ready, req_data, rsp_valid;
  logic [NREQ*XLEN-1:0] req_addr;
  logic [NREQ*NB-1:0] req_rmask, req_wmask;
  logic [NREQ*BUSLEN-1:0] req_wdata;
  logic [BUSLEN-1:0] rsp_rdata, mem_wdata, mem_rdata, rvfi_bus_rdata, rvfi_bus_wdata;
  logic mem_valid, mem_ready, rvfi_bus_valid, rvfi_bus_data;
  logic [XLEN-1:0] mem_addr, rvfi_bus_addr;
  logic [NB-1:0] mem_wstrb, rvfi_bus_rmask, rvfi_bus_wmask;

  rvfi_bus_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .BUSLEN(BUSLEN)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_rmask(req_rmask), .req_wmask(req_wmask), .req_wdata(req_wdata), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rvfi_bus_valid(rvfi_bus_valid), .rvfi_bus_data(rvfi_bus_data), .rvfi_bus_addr(rvfi_bus_addr),
    .rvfi_bus_rmask(rvfi_bus_rmask), .rvfi_bus_wmask(rvfi_bus_wmask),
    .rvfi_bus_rdata(rvfi_bus_rdata), .rvfi_bus_wdata(rvfi_bus_wdata)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int m_ptr = 0;

  // Observations collected by serve(); the test tasks compare them.
  logic [NREQ-1:0] obs_ready, obs_ready_busy, obs_rsp_v, obs_rsp_after;
  logic [BUSLEN-1:0] obs_rsp_d, obs_wdata, obs_tr_rdata, obs_tr_wdata;
  logic [XLEN-1:0] obs_addr, obs_tr_addr;
  logic [NB-1:0] obs_wstrb, obs_tr_rmask, obs_tr_wmask;
  logic obs_mv_first, obs_stable, obs_timeout, obs_tr_valid, obs_tr_data, obs_tr_after, obs_mv_end;
  int obs_wait;

  function automatic int rr_model(input logic [NREQ-1:0] v, input int p);
    for (int i = 0; i < NREQ; i++) begin
      if (v[(p + i) % NREQ]) return (p + i) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [31:0] keep_bytes(input logic [31:0] d, input logic [3:0] m);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  task automatic clear_inputs();
    req_valid = '0; req_addr = '0; req_rmask = '0; req_wmask = '0;
    req_wdata = '0; req_data = '0; mem_ready = 1'b0; mem_rdata = $urandom;
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [3:0] rm,
                         input logic [3:0] wm, input logic [31:0] wd, input logic d);
    req_valid[k] = 1'b1;
    req_addr[k*XLEN +: XLEN] = a;
    req_rmask[k*NB +: NB] = rm;
    req_wmask[k*NB +: NB] = wm;
    req_wdata[k*BUSLEN +: BUSLEN] = wd;
    req_data[k] = d;
  endtask

  // Called at a negedge in IDLE with requests driven; plays the memory with latency lat.
  task automatic serve(input int lat, input logic [31:0] rd);
    int gnt;
    int busy_cycles;
    #1;
    obs_ready = req_ready;
    gnt = -1;
    for (int k = NREQ - 1; k >= 0; k--) if (req_ready[k]) gnt = k;
    @(negedge clock);
    if (gnt >= 0) req_valid[gnt] = 1'b0;
    #1;
    obs_ready_busy = req_ready;
    obs_mv_first = mem_valid; obs_addr = mem_addr; obs_wstrb = mem_wstrb; obs_wdata = mem_wdata;
    obs_stable = 1'b1; obs_timeout = 1'b1; obs_wait = 0; busy_cycles = 0;
    for (int c = 0; c < 64; c++) begin
      if (rsp_valid !== '0) begin
        obs_timeout = 1'b0;
        obs_rsp_v = rsp_valid; obs_rsp_d = rsp_rdata;
        obs_tr_valid = rvfi_bus_valid; obs_tr_data = rvfi_bus_data; obs_tr_addr = rvfi_bus_addr;
        obs_tr_rmask = rvfi_bus_rmask; obs_tr_wmask = rvfi_bus_wmask;
        obs_tr_rdata = rvfi_bus_rdata; obs_tr_wdata = rvfi_bus_wdata;
        break;
      end
      if (mem_valid) begin
        if (mem_addr !== obs_addr || mem_wstrb !== obs_wstrb || mem_wdata !== obs_wdata) obs_stable = 1'b0;
        busy_cycles++;
        if (busy_cycles == lat + 1) begin
          mem_ready = 1'b1;
          mem_rdata = rd;
        end
      end
      @(negedge clock);
      mem_ready = 1'b0;
      mem_rdata = $urandom;
      #1;
      obs_wait++;
    end
    @(negedge clock);
    mem_ready = 1'b0;
    obs_rsp_after = rsp_valid; obs_tr_after = rvfi_bus_valid; obs_mv_end = mem_valid;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL reset_mem_valid: got=%b want=0", mem_valid); end
    total++; if (rsp_valid !== '0) begin bad++; $display("FAIL reset_rsp_valid: got=%b want=00", rsp_valid); end
    total++; if (rvfi_bus_valid !== 1'b0 || rvfi_bus_addr !== '0) begin bad++; $display("FAIL reset_rvfi: got=%b/%h want=0/0", rvfi_bus_valid, rvfi_bus_addr); end
    resetn = 1'b1;
    @(negedge clock);
    total++; if (req_ready !== '0 || rsp_rdata !== '0) begin bad++; $display("FAIL reset_idle: got=%b/%h want=00/0", req_ready, rsp_rdata); end
    m_ptr = 0;
  endtask

  task automatic test_round_robin();
    logic [31:0] rd;
    clear_inputs();
    set_req(0, 32'h10, 4'b0001, 4'b0000, 32'h0, 1'b1);
    set_req(1, 32'h20, 4'b0001, 4'b0000, 32'h0, 1'b1);
    rd = $urandom;
    serve(1, rd);
    total++; if (obs_ready !== 2'b01) begin bad++; $display("FAIL rr_first: got=%b want=01", obs_ready); end
    total++; if (obs_rsp_v !== 2'b01 || obs_rsp_d !== keep_bytes(rd, 4'b0001)) begin bad++; $display("FAIL rr_first_rsp: got=%b/%h want=01/%h", obs_rsp_v, obs_rsp_d, keep_bytes(rd, 4'b0001)); end
    total++; if (obs_ready_busy !== 2'b00) begin bad++; $display("FAIL rr_busy_ready: got=%b want=00", obs_ready_busy); end
    set_req(0, 32'h10, 4'b0001, 4'b0000, 32'h0, 1'b1);
    serve(0, $urandom);
    total++; if (obs_ready !== 2'b10 || obs_rsp_v !== 2'b10) begin bad++; $display("FAIL rr_second: got=%b/%b want=10/10", obs_ready, obs_rsp_v); end
    set_req(1, 32'h20, 4'b0001, 4'b0000, 32'h0, 1'b1);
    serve(2, $urandom);
    total++; if (obs_ready !== 2'b01) begin bad++; $display("FAIL rr_third: got=%b want=01", obs_ready); end
    m_ptr = 1;
  endtask

  task automatic test_read();
    clear_inputs();
    set_req(0, 32'h40, 4'b0011, 4'b0000, 32'hCAFE_F00D, 1'b1);
    serve(3, 32'hDEAD_BEEF);
    total++; if (obs_timeout !== 1'b0 || obs_wait != 4) begin bad++; $display("FAIL read_latency: got=%0d(to=%b) want=4", obs_wait, obs_timeout); end
    total++; if (obs_rsp_v !== 2'b01 || obs_rsp_d !== 32'h0000_BEEF) begin bad++; $display("FAIL read_data: got=%b/%h want=01/0000beef", obs_rsp_v, obs_rsp_d); end
    total++; if (obs_tr_valid !== TRACE || obs_tr_rdata !== (TRACE ? 32'h0000_BEEF : 32'h0)) begin bad++; $display("FAIL read_rvfi_rdata: got=%b/%h want=%b", obs_tr_valid, obs_tr_rdata, TRACE); end
    total++; if (obs_tr_rmask !== (TRACE ? 4'b0011 : 4'b0000) || obs_tr_data !== TRACE) begin bad++; $display("FAIL read_rvfi_fields: got=%b/%b", obs_tr_rmask, obs_tr_data); end
    total++; if (obs_rsp_after !== '0 || obs_tr_after !== 1'b0) begin bad++; $display("FAIL read_one_cycle: got=%b/%b want=00/0", obs_rsp_after, obs_tr_after); end
    m_ptr = 1;
  endtask

  task automatic test_write();
    clear_inputs();
    set_req(1, 32'h100, 4'b0000, 4'b1000, 32'h1122_3344, 1'b1);
    serve(2, $urandom);
    total++; if (obs_mv_first !== 1'b1 || obs_addr !== 32'h100) begin bad++; $display("FAIL write_addr: got=%b/%h want=1/100", obs_mv_first, obs_addr); end
    total++; if (obs_wstrb !== 4'b1000 || obs_wdata !== 32'h1122_3344) begin bad++; $display("FAIL write_data: got=%b/%h want=1000/11223344", obs_wstrb, obs_wdata); end
    total++; if (obs_stable !== 1'b1) begin bad++; $display("FAIL write_stable: got=%b want=1", obs_stable); end
    total++; if (obs_wait != 3 || obs_rsp_v !== 2'b10 || obs_rsp_d !== 32'h0) begin bad++; $display("FAIL write_rsp: got=%0d/%b/%h want=3/10/0", obs_wait, obs_rsp_v, obs_rsp_d); end
    total++; if (obs_tr_wdata !== (TRACE ? 32'h1122_3344 : 32'h0) || obs_tr_addr !== (TRACE ? 32'h100 : 32'h0)) begin bad++; $display("FAIL write_rvfi: got=%h/%h", obs_tr_wdata, obs_tr_addr); end
    m_ptr = 0;
  endtask

  task automatic test_zero_mask();
    clear_inputs();
    set_req(0, 32'h200, 4'b0000, 4'b0000, 32'h5555_AAAA, 1'b0);
    mem_ready = 1'b1;
    serve(0, $urandom);
    total++; if (obs_mv_first !== 1'b0 || obs_mv_end !== 1'b0) begin bad++; $display("FAIL zero_mem_valid: got=%b/%b want=0/0", obs_mv_first, obs_mv_end); end
    total++; if (obs_timeout !== 1'b0 || obs_wait != 0 || obs_rsp_v !== 2'b01) begin bad++; $display("FAIL zero_rsp: got=%0d/%b want=0/01", obs_wait, obs_rsp_v); end
    total++; if (obs_tr_valid !== TRACE || obs_tr_rmask !== 4'b0 || obs_tr_wmask !== 4'b0) begin bad++; $display("FAIL zero_rvfi: got=%b/%b/%b want=%b/0/0", obs_tr_valid, obs_tr_rmask, obs_tr_wmask, TRACE); end
    m_ptr = 1;
  endtask

  task automatic test_reset_in_busy();
    bit seen;
    clear_inputs();
    set_req(0, 32'h300, 4'b1111, 4'b0000, 32'h0, 1'b1);
    set_req(1, 32'h304, 4'b1111, 4'b0000, 32'h0, 1'b1);
    #1;
    total++; if (req_ready !== (NREQ'(1) << rr_model(req_valid, m_ptr))) begin bad++; $display("FAIL rb_grant: got=%b want=10", req_ready); end
    @(negedge clock);
    req_valid[1] = 1'b0;
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    req_valid = '0;
    total++; if (mem_valid !== 1'b0 || rsp_valid !== '0) begin bad++; $display("FAIL rb_abandon: got=%b/%b want=0/00", mem_valid, rsp_valid); end
    m_ptr = 0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clock);
      if (rsp_valid !== '0 || mem_valid !== 1'b0) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rb_no_rsp: got=%b want=0", seen); end
    set_req(0, 32'h300, 4'b1111, 4'b0000, 32'h0, 1'b1);
    set_req(1, 32'h304, 4'b1111, 4'b0000, 32'h0, 1'b1);
    serve(1, 32'h1234_5678);
    total++; if (obs_ready !== 2'b01 || obs_rsp_d !== 32'h1234_5678) begin bad++; $display("FAIL rb_regrant: got=%b/%h want=01/12345678", obs_ready, obs_rsp_d); end
    m_ptr = 1;
  endtask

  task automatic test_random();
    logic [31:0] s_addr[NREQ], s_wd[NREQ];
    logic [3:0] s_rm[NREQ], s_wm[NREQ];
    logic s_d[NREQ];
    logic [NREQ-1:0] vld;
    logic [31:0] rd;
    int lat, g;
    bit acc;
    for (int n = 0; n < 40; n++) begin
      clear_inputs();
      vld = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int k = 0; k < NREQ; k++) begin
        s_addr[k] = $urandom; s_wd[k] = $urandom; s_d[k] = 1'($urandom);
        s_rm[k] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
        s_wm[k] = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
        if (vld[k]) set_req(k, s_addr[k], s_rm[k], s_wm[k], s_wd[k], s_d[k]);
      end
      lat = $urandom_range(0, 4);
      rd = $urandom;
      g = rr_model(vld, m_ptr);
      acc = ((s_rm[g] | s_wm[g]) != 4'h0);
      serve(lat, rd);
      total++; if (obs_ready !== (NREQ'(1) << g) || obs_rsp_v !== (NREQ'(1) << g)) begin bad++; $display("FAIL rnd_grant[%0d]: got=%b/%b want=g%0d", n, obs_ready, obs_rsp_v, g); end
      total++; if (obs_timeout !== 1'b0 || obs_wait != (acc ? lat + 1 : 0) || obs_mv_first !== acc) begin bad++; $display("FAIL rnd_timing[%0d]: got=%0d/%b want=%0d/%b", n, obs_wait, obs_mv_first, acc ? lat + 1 : 0, acc); end
      total++; if (obs_rsp_d !== keep_bytes(rd, s_rm[g])) begin bad++; $display("FAIL rnd_rdata[%0d]: got=%h want=%h", n, obs_rsp_d, keep_bytes(rd, s_rm[g])); end
      if (acc) begin
        total++; if (obs_addr !== s_addr[g] || obs_wstrb !== s_wm[g] || obs_wdata !== s_wd[g] || obs_stable !== 1'b1) begin bad++; $display("FAIL rnd_mem[%0d]: got=%h/%b/%h/%b want=%h/%b/%h/1", n, obs_addr, obs_wstrb, obs_wdata, obs_stable, s_addr[g], s_wm[g], s_wd[g]); end
      end
      total++; if (obs_tr_valid !== TRACE || obs_tr_addr !== (TRACE ? s_addr[g] : 32'h0) || obs_tr_data !== (TRACE & s_d[g])
                   || obs_tr_rmask !== (TRACE ? s_rm[g] : 4'h0) || obs_tr_wmask !== (TRACE ? s_wm[g] : 4'h0)
                   || obs_tr_wdata !== (TRACE ? s_wd[g] : 32'h0) || obs_tr_rdata !== (TRACE ? keep_bytes(rd, s_rm[g]) : 32'h0)) begin
        bad++; $display("FAIL rnd_rvfi[%0d]: got=%b/%h/%b/%b/%b", n, obs_tr_valid, obs_tr_addr, obs_tr_data, obs_tr_rmask, obs_tr_wmask);
      end
      total++; if (obs_rsp_after !== '0 || obs_tr_after !== 1'b0) begin bad++; $display("FAIL rnd_one_cycle[%0d]: got=%b/%b want=00/0", n, obs_rsp_after, obs_tr_after); end
      m_ptr = (g + 1) % NREQ;
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_read();
    test_write();
    test_zero_mask();
    test_reset_in_busy();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
